// File: rtl/operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_sequencer_if
// Description : Control, memory, array and status signals of the operand
//               sequencer, bundled with sequencer/environment modports.
// Revision    : 1.0
// ============================================================================
interface operand_sequencer_if;
    logic [12:0] base_address;
    logic        load_weight;
    logic        load_input;
    logic        valid;
    logic        store;

    logic [12:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rd_data;
    logic        mem_wr_en;
    logic [15:0] mem_wr_data;

    logic [7:0]  weight_data;
    logic [1:0]  weight_idx;
    logic        weight_wr;

    logic [7:0]  in_row0;
    logic [7:0]  in_row1;
    logic        feed_valid;

    logic [15:0] acc_00;
    logic [15:0] acc_01;
    logic [15:0] acc_10;
    logic [15:0] acc_11;

    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  base_address, load_weight, load_input, valid, store,
        input  mem_rd_data, acc_00, acc_01, acc_10, acc_11,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output weight_data, weight_idx, weight_wr,
        output in_row0, in_row1, feed_valid,
        output busy, done, err
    );

    modport slave (
        output base_address, load_weight, load_input, valid, store,
        output mem_rd_data, acc_00, acc_01, acc_10, acc_11,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  weight_data, weight_idx, weight_wr,
        input  in_row0, in_row1, feed_valid,
        input  busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : operand_sequencer
// Description : Sequences weight loads, input loads, skewed feeds and result
//               stores for a 2x2 array. Define OPERAND_SEQUENCER_OVERLAP_ERR_EN
//               to flag dropped command edges on a sticky err output.
// Revision    : 1.0
// ============================================================================
module operand_sequencer (
    input  logic                       clk,
    input  logic                       reset,
    operand_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_ILOAD = 3'd2,
        S_FEED  = 3'd3,
        S_STORE = 3'd4
    } state_t;

    localparam logic [2:0] c_LOAD_LAST  = 3'd4;
    localparam logic [2:0] c_FEED_LAST  = 3'd2;
    localparam logic [2:0] c_STORE_LAST = 3'd3;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [12:0]     base_q, base_d;
    logic [3:0][7:0] a_q, a_d;
    logic [3:0]      strobe_prev_q;
    logic            armed_q;

    logic [3:0]      w_strobe;
    logic [3:0]      w_rise;
    logic [3:0]      w_grant;
    logic            w_accept;
    logic [12:0]     w_addr;
    logic [1:0]      w_prev_idx;

    // Bit 0 is the highest-priority command.
    assign w_strobe   = {bus.store, bus.valid, bus.load_input, bus.load_weight};
    // armed_q masks the first cycle after reset so strobes already high never fire.
    assign w_rise     = armed_q ? (w_strobe & ~strobe_prev_q) : 4'b0000;
    assign w_accept   = (state_q == S_IDLE) && (|w_rise);
    assign w_addr     = base_q + {10'd0, cnt_q};
    assign w_prev_idx = cnt_q[1:0] - 2'd1;

    always_comb begin
        w_grant = 4'b0000;
        if (w_rise[0]) begin
            w_grant = 4'b0001;
        end else if (w_rise[1]) begin
            w_grant = 4'b0010;
        end else if (w_rise[2]) begin
            w_grant = 4'b0100;
        end else if (w_rise[3]) begin
            w_grant = 4'b1000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 3'd0;
            base_q        <= 13'd0;
            a_q           <= '0;
            strobe_prev_q <= 4'b0000;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            a_q           <= a_d;
            strobe_prev_q <= w_strobe;
            armed_q       <= 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        base_d          = base_q;
        a_d             = a_q;
        bus.mem_addr    = 13'd0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 16'd0;
        bus.weight_data = 8'd0;
        bus.weight_idx  = 2'd0;
        bus.weight_wr   = 1'b0;
        bus.in_row0     = 8'd0;
        bus.in_row1     = 8'd0;
        bus.feed_valid  = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cnt_d  = 3'd0;
                    base_d = bus.base_address;
                    if (w_grant[0]) begin
                        state_d = S_WLOAD;
                    end else if (w_grant[1]) begin
                        state_d = S_ILOAD;
                    end else if (w_grant[2]) begin
                        state_d = S_FEED;
                    end else begin
                        state_d = S_STORE;
                    end
                end
            end

            // Read issued in cycle k returns in cycle k+1, so the write-back lags by one.
            S_WLOAD: begin
                bus.busy = 1'b1;
                if (cnt_q != c_LOAD_LAST) begin
                    bus.mem_rd_en = 1'b1;
                    bus.mem_addr  = w_addr;
                end
                if (cnt_q != 3'd0) begin
                    bus.weight_wr   = 1'b1;
                    bus.weight_idx  = w_prev_idx;
                    bus.weight_data = bus.mem_rd_data[7:0];
                end
                if (cnt_q == c_LOAD_LAST) begin
                    bus.done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_ILOAD: begin
                bus.busy = 1'b1;
                if (cnt_q != c_LOAD_LAST) begin
                    bus.mem_rd_en = 1'b1;
                    bus.mem_addr  = w_addr;
                end
                if (cnt_q != 3'd0) begin
                    a_d[w_prev_idx] = bus.mem_rd_data[7:0];
                end
                if (cnt_q == c_LOAD_LAST) begin
                    bus.done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            // Row 1 trails row 0 by one cycle to form the skewed wavefront.
            S_FEED: begin
                bus.busy       = 1'b1;
                bus.feed_valid = 1'b1;
                case (cnt_q)
                    3'd0: begin
                        bus.in_row0 = a_q[0];
                    end
                    3'd1: begin
                        bus.in_row0 = a_q[1];
                        bus.in_row1 = a_q[2];
                    end
                    default: begin
                        bus.in_row1 = a_q[3];
                    end
                endcase
                if (cnt_q == c_FEED_LAST) begin
                    bus.done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_STORE: begin
                bus.busy      = 1'b1;
                bus.mem_wr_en = 1'b1;
                bus.mem_addr  = w_addr;
                case (cnt_q[1:0])
                    2'd0:    bus.mem_wr_data = bus.acc_00;
                    2'd1:    bus.mem_wr_data = bus.acc_01;
                    2'd2:    bus.mem_wr_data = bus.acc_10;
                    default: bus.mem_wr_data = bus.acc_11;
                endcase
                if (cnt_q == c_STORE_LAST) begin
                    bus.done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef OPERAND_SEQUENCER_OVERLAP_ERR_EN
    logic err_q;
    logic w_overlap;

    // Any edge that does not become the accepted command counts as an overlap.
    assign w_overlap = (|w_rise) &&
                       ((state_q != S_IDLE) || ((w_rise & ~w_grant) != 4'b0000));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (w_overlap) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_sequencer
// Description : Directed bench with a per-cycle expected-output timeline model.
// Revision    : 1.0
// ============================================================================
module tb_operand_sequencer;

    localparam int MAXC = 512;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic        wr_en;
        logic [12:0] addr;
        logic [15:0] wdata;
        logic        wwr;
        logic [1:0]  widx;
        logic [7:0]  wdat;
        logic        fv;
        logic [7:0]  r0;
        logic [7:0]  r1;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    operand_sequencer_if bus ();

    operand_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_writes = 0;
    int   last_done = -1;
    int   err_set = -1;
    exp_t exp_tab [0:MAXC-1];
    logic [15:0] img [0:8191];
    logic [15:0] mem [0:8191];
    logic [7:0]  a_m [4];
    logic [7:0]  wq [$];
    logic [15:0] fq [$];

    logic        ld_en = 1'b0;
    logic [12:0] ld_addr = 13'd0;
    logic [15:0] ld_data = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle read latency; ld_* preloads contents during reset.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done) last_done <= cyc;
        if (bus.weight_wr) wq.push_back(bus.weight_data);
        if (bus.feed_valid) fq.push_back({bus.in_row0, bus.in_row1});
    end

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk) begin
        logic [61:0] act_v;
        logic [61:0] req_v;
        logic        req_err;
        if (cyc < MAXC) begin
`ifdef OPERAND_SEQUENCER_OVERLAP_ERR_EN
            req_err = (err_set >= 0) && (cyc >= err_set);
`else
            req_err = 1'b0;
`endif
            req_v = {exp_tab[cyc], req_err};
            act_v = {bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr,
                     bus.mem_wr_data, bus.weight_wr, bus.weight_idx, bus.weight_data,
                     bus.feed_valid, bus.in_row0, bus.in_row1, bus.err};
            check("cycle_outputs", {2'b00, act_v}, {2'b00, req_v});
        end
    end

    function automatic void sched_load(input bit to_buf, input logic [12:0] b, input int s);
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            logic [12:0] ra;
            e = '0;
            e.busy = 1'b1;
            if (k < 4) begin
                e.rd_en = 1'b1;
                e.addr  = b + 13'(k);
            end
            if (k > 0) begin
                ra = b + 13'(k - 1);
                if (to_buf) begin
                    a_m[k-1] = img[ra][7:0];
                end else begin
                    e.wwr  = 1'b1;
                    e.widx = 2'(k - 1);
                    e.wdat = img[ra][7:0];
                end
            end
            e.done = (k == 4);
            exp_tab[s+k] = e;
        end
    endfunction

    function automatic void sched_feed(input int s);
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e = '0;
            e.busy = 1'b1;
            e.fv   = 1'b1;
            e.r0   = (k == 0) ? a_m[0] : (k == 1) ? a_m[1] : 8'd0;
            e.r1   = (k == 1) ? a_m[2] : (k == 2) ? a_m[3] : 8'd0;
            e.done = (k == 2);
            exp_tab[s+k] = e;
        end
    endfunction

    function automatic void sched_store(input logic [12:0] b, input int s,
                                        input logic [15:0] v0, input logic [15:0] v1,
                                        input logic [15:0] v2, input logic [15:0] v3);
        logic [15:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e = '0;
            e.busy  = 1'b1;
            e.wr_en = 1'b1;
            e.addr  = b + 13'(k);
            e.wdata = v[k];
            e.done  = (k == 3);
            exp_tab[s+k] = e;
        end
    endfunction

    function automatic void model_reset(input int r);
        for (int c = r; c < MAXC; c++) exp_tab[c] = '0;
        for (int i = 0; i < 4; i++) a_m[i] = 8'd0;
        err_set = -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [12:0] a, input logic [15:0] d);
        img[a]  = d;
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        step(1);
        ld_en   = 1'b0;
    endtask

    task automatic set_acc(input logic [15:0] v0, input logic [15:0] v1,
                           input logic [15:0] v2, input logic [15:0] v3);
        bus.acc_00 = v0; bus.acc_01 = v1; bus.acc_10 = v2; bus.acc_11 = v3;
    endtask

    initial begin
        int s;
        int wsave;
        for (int c = 0; c < MAXC; c++) exp_tab[c] = '0;
        for (int i = 0; i < 4; i++) a_m[i] = 8'd0;
        bus.base_address = 13'd0;
        bus.load_weight  = 1'b0;
        bus.load_input   = 1'b0;
        bus.valid        = 1'b0;
        bus.store        = 1'b0;
        set_acc(16'd0, 16'd0, 16'd0, 16'd0);

        step(1);
        load_word(13'd100, 16'h0011);
        load_word(13'd101, 16'h0022);
        load_word(13'd102, 16'h0033);
        load_word(13'd103, 16'h0044);
        load_word(13'd200, 16'hAB01);
        load_word(13'd201, 16'hCD02);
        load_word(13'd202, 16'hEF03);
        load_word(13'd203, 16'h1204);
        reset = 1'b1;
        step(3);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);

        // FEED before any ILOAD carries an all-zero buffer.
        s = cyc + 1; sched_feed(s); bus.valid = 1'b1;
        step(5); bus.valid = 1'b0; step(2);

        // WLOAD; base changed after accept must not matter.
        wq.delete();
        bus.base_address = 13'd100;
        s = cyc + 1; sched_load(1'b0, 13'd100, s); bus.load_weight = 1'b1;
        step(1); bus.base_address = 13'h1FFF;
        step(6); bus.load_weight = 1'b0; step(2);
        check("wload_count", 64'(wq.size()), 64'd4);
        check("wload_w0", {56'd0, wq[0]}, 64'h11);
        check("wload_w1", {56'd0, wq[1]}, 64'h22);
        check("wload_w2", {56'd0, wq[2]}, 64'h33);
        check("wload_w3", {56'd0, wq[3]}, 64'h44);
        check("wload_done_cycle", 64'(last_done - s), 64'd4);

        // ILOAD then FEED.
        bus.base_address = 13'd200;
        s = cyc + 1; sched_load(1'b1, 13'd200, s); bus.load_input = 1'b1;
        step(6); bus.load_input = 1'b0; step(2);
        fq.delete();
        s = cyc + 1; sched_feed(s); bus.valid = 1'b1;
        step(5); bus.valid = 1'b0; step(2);
        check("feed_count", 64'(fq.size()), 64'd3);
        check("feed_c0", {48'd0, fq[0]}, 64'h0100);
        check("feed_c1", {48'd0, fq[1]}, 64'h0203);
        check("feed_c2", {48'd0, fq[2]}, 64'h0004);
        check("feed_done_cycle", 64'(last_done - s), 64'd2);

        // STORE wrapping across the top of the address space.
        set_acc(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        bus.base_address = 13'd8190;
        s = cyc + 1;
        sched_store(13'd8190, s, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
        bus.store = 1'b1;
        step(6); bus.store = 1'b0; step(2);
        check("store_8190", {48'd0, mem[8190]}, 64'h1000);
        check("store_8191", {48'd0, mem[8191]}, 64'h2000);
        check("store_0", {48'd0, mem[0]}, 64'h3000);
        check("store_1", {48'd0, mem[1]}, 64'h4000);

        // Simultaneous load_weight/store, then valid while busy.
        wsave = n_writes;
        bus.base_address = 13'd100;
        s = cyc + 1; sched_load(1'b0, 13'd100, s); err_set = s;
        bus.load_weight = 1'b1; bus.store = 1'b1;
        step(2); bus.valid = 1'b1;
        step(5);
        bus.load_weight = 1'b0; bus.store = 1'b0; bus.valid = 1'b0;
        step(2);
        check("prio_no_store", 64'(n_writes), 64'(wsave));
`ifdef OPERAND_SEQUENCER_OVERLAP_ERR_EN
        check("prio_err", {63'd0, bus.err}, 64'd1);
`else
        check("prio_err", {63'd0, bus.err}, 64'd0);
`endif

        // load_input held high across completion.
        bus.base_address = 13'd200;
        s = cyc + 1; sched_load(1'b1, 13'd200, s); bus.load_input = 1'b1;
        step(12);
        check("held_busy_low", {63'd0, bus.busy}, 64'd0);
        bus.load_input = 1'b0; step(2);

        // Reset asserted during STORE k=1 with store held through release.
        set_acc(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        bus.base_address = 13'd300;
        s = cyc + 1;
        sched_store(13'd300, s, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        bus.store = 1'b1;
        step(2);
        reset = 1'b0; model_reset(cyc);
        #1;
        check("rst_wr_en", {63'd0, bus.mem_wr_en}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        step(1);
        wsave = n_writes;
        step(2);
        reset = 1'b1;
        step(10);
        check("rst_no_write", 64'(n_writes), 64'(wsave));
        check("rst_err", {63'd0, bus.err}, 64'd0);
        check("rst_mem_300", {48'd0, mem[300]}, 64'hAAAA);
        bus.store = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low (0 = in reset).
REQ-003 SHALL have: base_address  input  13  operand/result base word address from control.
REQ-004 SHALL have: load_weight, load_input, valid, store  input  1 each  control strobes (level, may stay high).
REQ-005 SHALL have: mem_addr  output  13; mem_rd_en  output  1; mem_rd_data  input  16 (1-cycle read latency); mem_wr_en  output  1; mem_wr_data  output  16.
REQ-006 SHALL have: weight_data  output  8; weight_idx  output  2; weight_wr  output  1  weight writes into 2x2 array.
REQ-007 SHALL have: in_row0, in_row1  output  8 each; feed_valid  output  1  skewed array inputs.
REQ-008 SHALL have: acc_00, acc_01, acc_10, acc_11  input  16 each  array results.
REQ-009 SHALL have: busy  output  1; done  output  1  one-cycle completion pulse; err  output  1.

Function
REQ-010 SHALL detect commands on 0->1 edges of each strobe (registered previous value); levels SHALL NOT retrigger.
REQ-011 SHALL accept a command only in IDLE; simultaneous edges priority: load_weight > load_input > valid > store; lower-priority edges that cycle dropped.
REQ-012 SHALL latch base_address on the accept cycle; later base_address changes ignored until next accept.
REQ-013 States: IDLE, WLOAD, ILOAD, FEED, STORE; all return to IDLE with done=1 for exactly one cycle on the final cycle.
REQ-014 WLOAD: issue cycles k=0..3 drive mem_rd_en=1, mem_addr=base+k; cycle k+1 drives weight_wr=1, weight_idx=k, weight_data=mem_rd_data[7:0]; 5 cycles total.
REQ-015 ILOAD: same read timing; data[7:0] stored into internal buffer A[k] (A00,A01,A10,A11 order); no array outputs; 5 cycles.
REQ-016 FEED: 3 cycles, feed_valid=1; cycle0 row0=A00,row1=0; cycle1 row0=A01,row1=A10; cycle2 row0=0,row1=A11.
REQ-017 STORE: 4 cycles, mem_wr_en=1, mem_addr=base+k, mem_wr_data=acc_00,acc_01,acc_10,acc_11 for k=0..3; acc sampled each cycle.
REQ-018 Address arithmetic SHALL be modulo 2^13 (base 8191 -> 8191,0,1,2).
REQ-019 busy SHALL be 1 in every non-IDLE state; outputs not named active in a state SHALL be 0.
REQ-020 mem_rd_en and mem_wr_en SHALL never be 1 in the same cycle.
REQ-021 Internal A buffer SHALL persist across commands; FEED without prior ILOAD emits zeros.

Reset
REQ-022 Reset assertion SHALL immediately force IDLE, all outputs 0, A buffer 0, edge registers 0, err 0, including mid-operation.
REQ-023 After reset release, strobes already high SHALL NOT create a command until they fall and rise again.

Configuration
REQ-024 Macro OPERAND_SEQUENCER_OVERLAP_ERR_EN: defined -> any command edge arriving while busy=1 (or dropped by priority) sets err=1, sticky until reset; undefined -> such edges silently dropped, err tied 0.

Verification
REQ-025 WLOAD: mem[100..103]=0x0011,0x0022,0x0033,0x0044, base=100, load_weight rise -> weight_wr 4 cycles idx 0..3 data 11,22,33,44; done at cycle 5.
REQ-026 ILOAD base=200 data 1,2,3,4 then valid rise -> feed: (1,0),(2,3),(0,4), feed_valid 3 cycles, done on third.
REQ-027 STORE base=8190, acc=0x1000,0x2000,0x3000,0x4000 -> writes addr 8190,8191,0,1 with those values.
REQ-028 load_weight and store rise same cycle -> only WLOAD executes; err=1 only with macro defined.
REQ-029 Reset low during STORE k=1 -> mem_wr_en=0, busy=0 immediately; after release with store held high, no write.
REQ-030 load_input held high across ILOAD completion -> no second ILOAD; busy low after 5 cycles.
